// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: parametrised control-word pipeline from decode through
// ID/EX .. MEM/WB. Provides a global hold (LE), bubble insertion at the entry
// stage (SS), a per-stage flush and per-stage valid bits.
// Optional statistics counters are built only when CTRL_PIPE_STATS_EN is
// defined; otherwise bubble_cnt and retire_cnt are tied to zero.
module ctrl_pipe_chain #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic                      LE,
  input  logic                      SS,
  input  logic [WIDTH-1:0]          id_ctrl,
  input  logic                      id_valid,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   stage_ctrl,
  output logic [STAGES-1:0]         stage_valid,
  output logic [CNT_W-1:0]          bubble_cnt,
  output logic [CNT_W-1:0]          retire_cnt
);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0]  ctrl_q [STAGES];
  logic [WIDTH-1:0]  ctrl_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;

  // Source of each stage: entry word for stage 0, previous stage otherwise.
  logic [WIDTH-1:0]  src_ctrl [STAGES];
  logic [STAGES-1:0] src_valid;

  // Entry mux plus shift-source selection; bubble words are forced to zero.
  always_comb begin
    src_valid[0] = ~SS & id_valid;
    src_ctrl[0]  = src_valid[0] ? id_ctrl : '0;
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_ctrl[k]  = ctrl_q[k-1];
    end
  end

  // Next-state per stage: flush wins even during a hold, so it is never lost.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = valid_q[k];
      ctrl_d[k]  = ctrl_q[k];
      if (flush[k]) begin
        valid_d[k] = 1'b0;
        ctrl_d[k]  = '0;
      end else if (LE) begin
        valid_d[k] = src_valid[k];
        ctrl_d[k]  = src_ctrl[k];
      end
    end
  end

  // Stage registers; reset drops every in-flight word.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) ctrl_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) ctrl_q[k] <= ctrl_d[k];
    end
  end

  // Flatten stage words onto the output bus, stage k at [k*WIDTH +: WIDTH].
  always_comb begin
    stage_ctrl = '0;
    for (int k = 0; k < STAGES; k++) stage_ctrl[k*WIDTH +: WIDTH] = ctrl_q[k];
  end

  assign stage_valid = valid_q;

`ifdef CTRL_PIPE_STATS_EN
  logic [CNT_W-1:0] bubble_q, bubble_d;
  logic [CNT_W-1:0] retire_q, retire_d;

  // Bubble count follows inserted bubbles; retire count follows valid words
  // shifted out of the last stage (flush never affects the leaving word).
  always_comb begin
    bubble_d = bubble_q;
    retire_d = retire_q;
    if (LE && SS)                  bubble_d = sat_inc(bubble_q);
    if (LE && valid_q[STAGES-1])   retire_d = sat_inc(retire_q);
  end

  // Statistics registers, cleared with the pipeline.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      bubble_q <= '0;
      retire_q <= '0;
    end else begin
      bubble_q <= bubble_d;
      retire_q <= retire_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign retire_cnt = retire_q;
`else
  assign bubble_cnt = '0;
  assign retire_cnt = '0;
`endif

endmodule
